// File: rtl/kbd_pkg.sv
// Shared constants and helpers for the keyboard scancode path.
package kbd_pkg;

  localparam logic [7:0] KBD_OVERFLOW_CODE = 8'hFF;
  localparam logic [7:0] KBD_EMPTY_CODE    = 8'h00;

  function automatic int depth(input int depth_log2);
    return 1 << depth_log2;
  endfunction

endpackage

// File: rtl/kbd_fifo_mem.sv
// Scancode storage: circular buffer with occupancy count; write and pop take effect next cycle.
// A push into a full buffer is accepted only when a pop frees the slot in the same cycle.
module kbd_fifo_mem
  import kbd_pkg::*;
#(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  push,
  input  logic                  pop,
  input  logic                  flush,
  input  logic [7:0]            din,
  output logic [7:0]            dout,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  full,
  output logic                  empty
);

  localparam int                DEPTH     = depth(DEPTH_LOG2);
  localparam logic [DEPTH_LOG2:0] DEPTH_CNT = (DEPTH_LOG2 + 1)'(DEPTH);

  logic [7:0]            mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic                  do_push;
  logic                  do_pop;

  assign empty   = (count == '0);
  assign full    = (count == DEPTH_CNT);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + DEPTH_LOG2'(1);
      if (do_pop)  rd_ptr <= rd_ptr + DEPTH_LOG2'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (DEPTH_LOG2 + 1)'(1);
        2'b01:   count <= count - (DEPTH_LOG2 + 1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage carries no reset; empty slots are never presented.
  always_ff @(posedge clock) begin
    if (do_push && !flush) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/kbd_scancode_fifo.sv
// Captures converter keycodes into a FIFO and presents the head as port 60h data with IRQ1.
// Capture acknowledged by a one-cycle clear pulse; irq1 is held off IRQ_GAP cycles after each pop.
// Optional KBD_FIFO_OVERFLOW_MARK_EN inserts a 0xFF marker after codes were lost to a full FIFO.
module kbd_scancode_fifo
  import kbd_pkg::*;
#(
  parameter int DEPTH_LOG2 = 4,
  parameter int IRQ_GAP    = 4
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                kb_irq,
  input  logic [7:0]          kb_keycode,
  output logic                kb_clear_keycode,
  input  logic                cpu_ack,
  input  logic                flush,
  output logic [7:0]          data_out,
  output logic                irq1,
  output logic [DEPTH_LOG2:0] count
);

  localparam int               GAP_W    = (IRQ_GAP > 0) ? $clog2(IRQ_GAP + 1) : 1;
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(IRQ_GAP);

  logic             capture;
  logic             pop;
  logic             push;
  logic             marker_push;
  logic             full;
  logic             empty;
  logic [7:0]       din;
  logic [7:0]       head;
  logic [GAP_W-1:0] gap_cnt;
  logic [GAP_W-1:0] gap_next;

`ifdef KBD_FIFO_OVERFLOW_MARK_EN
  logic ovf_pending;

  assign marker_push = ovf_pending && !full && !flush;

  always_ff @(posedge clock or posedge reset) begin
    if (reset)                           ovf_pending <= 1'b0;
    else if (flush)                      ovf_pending <= 1'b0;
    else if (marker_push)                ovf_pending <= 1'b0;
    else if (capture && full && !pop)    ovf_pending <= 1'b1;
  end
`else
  assign marker_push = 1'b0;
`endif

  // The clear guard keeps a still-high kb_irq from being taken twice.
  assign capture  = kb_irq && !kb_clear_keycode && !flush && !marker_push;
  assign pop      = cpu_ack && !empty && !flush;
  assign push     = marker_push || (capture && (!full || pop));
  assign din      = marker_push ? KBD_OVERFLOW_CODE : kb_keycode;
  assign data_out = empty ? KBD_EMPTY_CODE : head;

  kbd_fifo_mem #(
    .DEPTH_LOG2(DEPTH_LOG2)
  ) u_mem (
    .clock (clock),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .flush (flush),
    .din   (din),
    .dout  (head),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  always_comb begin
    gap_next = gap_cnt;
    if (flush)             gap_next = '0;
    else if (pop)          gap_next = GAP_LOAD;
    else if (gap_cnt != 0) gap_next = gap_cnt - GAP_W'(1);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      kb_clear_keycode <= 1'b0;
      gap_cnt          <= '0;
      irq1             <= 1'b0;
    end else begin
      kb_clear_keycode <= capture;
      gap_cnt          <= gap_next;
      // Low for exactly IRQ_GAP cycles after a pop, giving the 8259 a fresh edge.
      irq1             <= !flush && !pop && !empty && (gap_next == '0);
    end
  end

endmodule

// File: tb/tb_kbd_scancode_fifo.sv
// Directed bench for kbd_scancode_fifo; popped codes checked against an expected-code queue.
module tb_kbd_scancode_fifo;

  logic       clock;
  logic       reset;
  logic       kb_irq;
  logic [7:0] kb_keycode;
  logic       kb_clear_keycode;
  logic       cpu_ack;
  logic       flush;
  logic [7:0] data_out;
  logic       irq1;
  logic [4:0] count;

  int         checks   = 0;
  int         failures = 0;
  logic [7:0] exp_q[$];

  kbd_scancode_fifo #(
    .DEPTH_LOG2(4),
    .IRQ_GAP   (4)
  ) dut (
    .clock            (clock),
    .reset            (reset),
    .kb_irq           (kb_irq),
    .kb_keycode       (kb_keycode),
    .kb_clear_keycode (kb_clear_keycode),
    .cpu_ack          (cpu_ack),
    .flush            (flush),
    .data_out         (data_out),
    .irq1             (irq1),
    .count            (count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  // Converter model: holds kb_irq until it has seen the clear pulse.
  task automatic send(input logic [7:0] code);
    kb_irq     = 1'b1;
    kb_keycode = code;
    cyc();
    chk("clear_pulse", kb_clear_keycode, 1);
    cyc();
    chk("clear_once", kb_clear_keycode, 0);
    kb_irq = 1'b0;
  endtask

  task automatic drain();
    cpu_ack = 1'b1;
    for (int i = 0; i < 40 && count != 0; i++) cyc();
    cpu_ack = 1'b0;
    chk("drain_count", count, 0);
    chk("drain_queue_left", exp_q.size(), 0);
  endtask

  // Monitor: every accepted pop must present the oldest expected code.
  always @(negedge clock) begin
    if (!reset && cpu_ack && count != 0) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL pop_unexpected data_out=%0h with no code expected at %0t", data_out, $time);
      end else begin
        chk("pop_data", data_out, exp_q.pop_front());
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    reset      = 1'b1;
    kb_irq     = 1'b0;
    kb_keycode = 8'h00;
    cpu_ack    = 1'b0;
    flush      = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    chk("rst_clear", kb_clear_keycode, 0);
    chk("rst_data", data_out, 8'h00);
    chk("rst_irq1", irq1, 0);
    chk("rst_count", count, 0);
    reset = 1'b0;
    cyc();

    // 1: one code, one capture, irq1 one cycle after count
    kb_irq = 1'b1;
    kb_keycode = 8'h1E;
    exp_q.push_back(8'h1E);
    cyc();
    chk("t1_clear", kb_clear_keycode, 1);
    chk("t1_count", count, 1);
    chk("t1_data", data_out, 8'h1E);
    chk("t1_irq_early", irq1, 0);
    cyc();
    chk("t1_clear_guard", kb_clear_keycode, 0);
    chk("t1_irq", irq1, 1);
    kb_irq = 1'b0;
    cyc();
    chk("t1_count_single", count, 1);

    // 2: pop opens a 4-cycle irq1 gap
    send(8'h9E);
    exp_q.push_back(8'h9E);
    chk("t2_count2", count, 2);
    cpu_ack = 1'b1;
    cyc();
    cpu_ack = 1'b0;
    chk("t2_count1", count, 1);
    chk("t2_data", data_out, 8'h9E);
    for (int i = 0; i < 4; i++) begin
      chk("t2_irq_gap", irq1, 0);
      cyc();
    end
    chk("t2_irq_back", irq1, 1);
    cpu_ack = 1'b1;
    cyc();
    cpu_ack = 1'b0;
    chk("t2_empty_count", count, 0);
    chk("t2_empty_data", data_out, 8'h00);
    chk("t2_empty_irq", irq1, 0);
    repeat (6) cyc();
    chk("t2_irq_stays_low", irq1, 0);

    // 3: overflow while full
    for (int i = 0; i < 16; i++) begin
      send(8'h10 + 8'(i));
      exp_q.push_back(8'h10 + 8'(i));
    end
    chk("t3_full", count, 16);
    send(8'h30);
    chk("t3_drop_count", count, 16);
    cpu_ack = 1'b1;
`ifdef KBD_FIFO_OVERFLOW_MARK_EN
    exp_q.push_back(8'hFF);
`endif
    cyc();
    cpu_ack = 1'b0;
    chk("t3_after_ack", count, 15);
    cyc();
`ifdef KBD_FIFO_OVERFLOW_MARK_EN
    chk("t3_marker_count", count, 16);
`else
    chk("t3_no_marker_count", count, 15);
`endif
    cpu_ack = 1'b1;
    cyc();
    cpu_ack = 1'b0;
    send(8'h2C);
    exp_q.push_back(8'h2C);
`ifdef KBD_FIFO_OVERFLOW_MARK_EN
    chk("t3_after_2c", count, 16);
`else
    chk("t3_after_2c", count, 15);
`endif
    drain();

    // 4: capture and pop together while full
    for (int i = 0; i < 16; i++) begin
      send(8'h40 + 8'(i));
      exp_q.push_back(8'h40 + 8'(i));
    end
    chk("t4_full", count, 16);
    kb_irq     = 1'b1;
    kb_keycode = 8'h55;
    cpu_ack    = 1'b1;
    exp_q.push_back(8'h55);
    cyc();
    cpu_ack = 1'b0;
    chk("t4_clear", kb_clear_keycode, 1);
    chk("t4_count", count, 16);
    chk("t4_head", data_out, 8'h41);
    cyc();
    kb_irq = 1'b0;
    chk("t4_clear_guard", kb_clear_keycode, 0);
    drain();

    // 5: flush discards queue and coincident capture
    send(8'h61);
    send(8'h62);
    send(8'h63);
    chk("t5_count3", count, 3);
    flush      = 1'b1;
    kb_irq     = 1'b1;
    kb_keycode = 8'h64;
    cyc();
    exp_q.delete();
    chk("t5_no_clear", kb_clear_keycode, 0);
    chk("t5_count", count, 0);
    chk("t5_irq", irq1, 0);
    chk("t5_data", data_out, 8'h00);
    flush = 1'b0;
    cyc();
    chk("t5_recapture_clear", kb_clear_keycode, 1);
    chk("t5_recapture_count", count, 1);
    chk("t5_recapture_data", data_out, 8'h64);
    exp_q.push_back(8'h64);
    cyc();
    kb_irq = 1'b0;
    drain();

    // 6: async reset mid-gap
    send(8'h71);
    exp_q.push_back(8'h71);
    send(8'h72);
    send(8'h73);
    cpu_ack = 1'b1;
    cyc();
    cpu_ack = 1'b0;
    chk("t6_count2", count, 2);
    cyc();
    chk("t6_mid_gap", irq1, 0);
    #3;
    reset = 1'b1;
    #1;
    chk("t6_rst_clear", kb_clear_keycode, 0);
    chk("t6_rst_data", data_out, 8'h00);
    chk("t6_rst_irq", irq1, 0);
    chk("t6_rst_count", count, 0);
    exp_q.delete();
    cyc();
    cyc();
    reset = 1'b0;
    cyc();
    send(8'h2A);
    exp_q.push_back(8'h2A);
    chk("t6_resume_count", count, 1);
    chk("t6_resume_data", data_out, 8'h2A);
    chk("t6_resume_irq", irq1, 1);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
